// File: rtl/pe_border_mc_if.sv
// Handshake and data bundle for pe_border_mc.
// The master drives requests and operands; the slave returns status and forwarded streams.
interface pe_border_mc_if #(
   parameter int IWIDTH = 8,
   parameter int OWIDTH = 16,
   parameter int LANES  = 4,
   parameter int LW     = $clog2(IWIDTH)
);
   logic                          start;
   logic                          wght_ld;
   logic [LW-1:0]                 cyc_len;
   logic [IWIDTH-1:0]             ifm;
   logic [LANES*IWIDTH-1:0]       wght;
   logic [LANES*OWIDTH-1:0]       ofm;
   logic                          busy;
   logic                          done;
   logic [LANES*OWIDTH-1:0]       ofm_d;
   logic                          ifm_sign_d;
   logic                          ifm_bit_d;
   logic [LANES*(IWIDTH-1)-1:0]   randW_d;

   modport master (
      output start, wght_ld, cyc_len, ifm, wght, ofm,
      input  busy, done, ofm_d, ifm_sign_d, ifm_bit_d, randW_d
   );

   modport slave (
      input  start, wght_ld, cyc_len, ifm, wght, ofm,
      output busy, done, ofm_d, ifm_sign_d, ifm_bit_d, randW_d
   );
endinterface

// File: rtl/pe_border_mc.sv
// Weight-stationary border PE: unary-stream multiply of one activation against LANES
// stored weights, with saturating accumulation onto loaded partial sums.
module pe_border_mc #(
   parameter int IWIDTH = 8,
   parameter int OWIDTH = 16,
   parameter int LANES  = 4,
   parameter int LW     = $clog2(IWIDTH)
) (
   input logic            clk,
   input logic            rst_n,
   pe_border_mc_if.slave  bus
);
   localparam int MW = IWIDTH - 1;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [OWIDTH-1:0] ACC_MAX = {1'b0, {(OWIDTH-1){1'b1}}};
   localparam logic [OWIDTH-1:0] ACC_MIN = {1'b1, {(OWIDTH-1){1'b0}}};

   function automatic logic [MW-1:0] sat_abs(input logic [IWIDTH-1:0] v);
      logic [IWIDTH-1:0] n;
      n = v[IWIDTH-1] ? (~v + 1'b1) : v;
      return n[IWIDTH-1] ? '1 : n[MW-1:0];
   endfunction

   function automatic logic [MW-1:0] bitrev(input logic [MW-1:0] v);
      logic [MW-1:0] r;
      for (int unsigned i = 0; i < MW; i++) r[i] = v[MW-1-i];
      return r;
   endfunction

   logic [1:0]                      state_q, state_d;
   logic [MW-1:0]                   cnt_q, cnt_d;
   logic [LW-1:0]                   len_q, len_d;
   logic                            isign_q, isign_d;
   logic [MW-1:0]                   iabs_q, iabs_d;
   logic [LANES-1:0]                wsign_q, wsign_d;
   logic [LANES-1:0][MW-1:0]        wabs_q, wabs_d;
   logic [LANES-1:0][MW-1:0]        wcnt_q, wcnt_d;
   logic [LANES-1:0][OWIDTH-1:0]    acc_q, acc_d;
   logic [LANES*OWIDTH-1:0]         ofm_out_q, ofm_out_d;
   logic                            ibit_q, ibit_d;
   logic [LANES*MW-1:0]             randw_q, randw_d;

   logic                            ibit;
   logic                            last;
   logic [LANES-1:0][MW-1:0]        rng_w;

   assign ibit = iabs_q > bitrev(cnt_q);
   // Final RUN cycle index is N-1; the MW-bit wrap makes N = 2^MW land on all-ones.
   assign last = (cnt_q == ((MW'(1) << len_q) - MW'(1)));

   always_comb begin
      for (int unsigned l = 0; l < LANES; l++) rng_w[l] = bitrev(wcnt_q[l]);
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      isign_d   = isign_q;
      iabs_d    = iabs_q;
      wsign_d   = wsign_q;
      wabs_d    = wabs_q;
      wcnt_d    = wcnt_q;
      acc_d     = acc_q;
      ofm_out_d = ofm_out_q;
      ibit_d    = 1'b0;
      randw_d   = randw_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_RUN;
               cnt_d   = '0;
               len_d   = (bus.cyc_len > LW'(MW)) ? LW'(MW) : bus.cyc_len;
               isign_d = bus.ifm[IWIDTH-1];
               iabs_d  = sat_abs(bus.ifm);
               for (int unsigned l = 0; l < LANES; l++) begin
                  acc_d[l]  = bus.ofm[l*OWIDTH +: OWIDTH];
                  wcnt_d[l] = '0;
                  if (bus.wght_ld) begin
                     wsign_d[l] = bus.wght[l*IWIDTH + IWIDTH - 1];
                     wabs_d[l]  = sat_abs(bus.wght[l*IWIDTH +: IWIDTH]);
                  end
               end
            end
         end
         S_RUN: begin
            ibit_d = ibit;
            cnt_d  = cnt_q + 1'b1;
            for (int unsigned l = 0; l < LANES; l++) begin
               randw_d[l*MW +: MW] = rng_w[l];
               if (ibit) begin
                  wcnt_d[l] = wcnt_q[l] + 1'b1;
                  if (wabs_q[l] > rng_w[l]) begin
                     if (isign_q == wsign_q[l]) begin
                        if (acc_q[l] != ACC_MAX) acc_d[l] = acc_q[l] + 1'b1;
                     end else begin
                        if (acc_q[l] != ACC_MIN) acc_d[l] = acc_q[l] - 1'b1;
                     end
                  end
               end
            end
            if (last) begin
               state_d   = S_DONE;
               ofm_out_d = acc_d;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         len_q     <= '0;
         isign_q   <= 1'b0;
         iabs_q    <= '0;
         wsign_q   <= '0;
         wabs_q    <= '0;
         wcnt_q    <= '0;
         acc_q     <= '0;
         ofm_out_q <= '0;
         ibit_q    <= 1'b0;
         randw_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         isign_q   <= isign_d;
         iabs_q    <= iabs_d;
         wsign_q   <= wsign_d;
         wabs_q    <= wabs_d;
         wcnt_q    <= wcnt_d;
         acc_q     <= acc_d;
         ofm_out_q <= ofm_out_d;
         ibit_q    <= ibit_d;
         randw_q   <= randw_d;
      end
   end

   assign bus.busy       = (state_q != S_IDLE);
   assign bus.done       = (state_q == S_DONE);
   assign bus.ofm_d      = ofm_out_q;
   assign bus.ifm_sign_d = isign_q;
   assign bus.ifm_bit_d  = ibit_q;
   assign bus.randW_d    = randw_q;
endmodule
